// File: rtl/rgb_duty_seg_display.sv
// rgb_duty_seg_display
//   Shows the live red/green/blue duty values in decimal on an 8-digit
//   multiplexed seven-segment display. A sequential double-dabble converter
//   walks R->G->B and stages BCD results. Staged digits are copied to the
//   displayed set only when the scan wraps from slot 7 to slot 0, so a frame
//   is never torn.
// Ports
//   CLK        system clock (rising edge)
//   RST        asynchronous reset, active low
//   R/G/B_DUTY unsigned duty values, CH_W bits each
//   CA         cathodes, active low, {DP,g,f,e,d,c,b,a}
//   AN         anodes, active low, one-hot-low (AN[i] = slot i)
//   CONV_DONE  1-cycle pulse after a full R,G,B set has been staged
module rgb_duty_seg_display #(
   parameter int unsigned CH_W        = 5,
   parameter int unsigned REFRESH_DIV = 100000,
   parameter bit          LZ_BLANK    = 1'b1
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [CH_W-1:0] R_DUTY,
   input  logic [CH_W-1:0] G_DUTY,
   input  logic [CH_W-1:0] B_DUTY,
   output logic [7:0]      CA,
   output logic [7:0]      AN,
   output logic            CONV_DONE
);
   localparam int unsigned PW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned CNW = (CH_W > 1) ? $clog2(CH_W + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_WRITE} cst_e;

   cst_e            st_q;
   logic [1:0]      ch_q;       // 0=R 1=G 2=B
   logic [CH_W-1:0] sh_q;
   logic [7:0]      bcd_q;      // {tens, ones}
   logic [7:0]      bcd_adj;
   logic [CNW-1:0]  cnt_q;
   logic            done_q;
   logic [2:0][7:0] stg_q;      // [0]=R [1]=G [2]=B, {tens, ones}
   logic [2:0][7:0] disp_q;

   logic [PW-1:0]   pre_q;
   logic [2:0]      idx_q;
   logic            arm_q;
   logic [7:0]      an_q, ca_q, ca_d;
   logic            tc;

   // Double-dabble correction applied before each shift.
   always_comb begin
      bcd_adj = bcd_q;
      if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
      if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         st_q   <= S_IDLE;
         ch_q   <= 2'd0;
         sh_q   <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
         stg_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (st_q)
            S_IDLE: st_q <= S_LOAD;
            S_LOAD: begin
               case (ch_q)
                  2'd1:    sh_q <= G_DUTY;
                  2'd2:    sh_q <= B_DUTY;
                  default: sh_q <= R_DUTY;
               endcase
               bcd_q <= '0;
               cnt_q <= '0;
               st_q  <= S_SHIFT;
            end
            S_SHIFT: begin
               bcd_q <= {bcd_adj[6:0], sh_q[CH_W-1]};
               sh_q  <= sh_q << 1;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNW'(CH_W - 1)) st_q <= S_WRITE;
            end
            default: begin // S_WRITE
               case (ch_q)
                  2'd1:    stg_q[1] <= bcd_q;
                  2'd2:    stg_q[2] <= bcd_q;
                  default: stg_q[0] <= bcd_q;
               endcase
               done_q <= (ch_q == 2'd2);
               ch_q   <= (ch_q == 2'd2) ? 2'd0 : ch_q + 2'd1;
               st_q   <= S_LOAD;
            end
         endcase
      end
   end

   function automatic logic [7:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 8'hC0;
         4'd1:    seg7 = 8'hF9;
         4'd2:    seg7 = 8'hA4;
         4'd3:    seg7 = 8'hB0;
         4'd4:    seg7 = 8'h99;
         4'd5:    seg7 = 8'h92;
         4'd6:    seg7 = 8'h82;
         4'd7:    seg7 = 8'hF8;
         4'd8:    seg7 = 8'h80;
         4'd9:    seg7 = 8'h90;
         default: seg7 = 8'hFF;
      endcase
   endfunction

   function automatic logic [7:0] tens7(input logic [3:0] d);
      tens7 = (LZ_BLANK && d == 4'd0) ? 8'hFF : seg7(d);
   endfunction

   always_comb begin
      ca_d = 8'hFF;
      case (idx_q)
         3'd7: ca_d = tens7(disp_q[0][7:4]);
         3'd6: ca_d = seg7(disp_q[0][3:0]);
         3'd4: ca_d = tens7(disp_q[1][7:4]);
         3'd3: ca_d = seg7(disp_q[1][3:0]);
         3'd1: ca_d = tens7(disp_q[2][7:4]);
         3'd0: ca_d = seg7(disp_q[2][3:0]);
         default: ca_d = 8'hFF;
      endcase
   end

   assign tc = (pre_q == PW'(REFRESH_DIV - 1));

   // The first terminal count after reset lights slot 0 instead of
   // advancing, so the scan always starts at slot 0.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pre_q  <= '0;
         idx_q  <= 3'd0;
         arm_q  <= 1'b0;
         disp_q <= '0;
         an_q   <= 8'hFF;
         ca_q   <= 8'hFF;
      end else begin
         if (tc) begin
            pre_q <= '0;
            arm_q <= 1'b1;
            if (arm_q) begin
               idx_q <= idx_q + 3'd1;
               if (idx_q == 3'd7) disp_q <= stg_q;
            end
         end else begin
            pre_q <= pre_q + 1'b1;
         end
         an_q <= arm_q ? ~(8'b1 << idx_q) : 8'hFF;
         ca_q <= arm_q ? ca_d : 8'hFF;
      end
   end

   assign AN        = an_q;
   assign CA        = ca_q;
   assign CONV_DONE = done_q;
endmodule

// File: tb/tb_rgb_duty_seg_display.sv
module tb_rgb_duty_seg_display;
   localparam int CH_W = 5;
   localparam int DIV  = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [CH_W-1:0] r = '0, g = '0, b = '0;
   logic [7:0]      ca, an, ca_nz, an_nz;
   logic            done, done_nz;

   always #5 clk = ~clk;

   rgb_duty_seg_display #(.CH_W(CH_W), .REFRESH_DIV(DIV), .LZ_BLANK(1'b1)) u_dut (
      .CLK(clk), .RST(rst_n), .R_DUTY(r), .G_DUTY(g), .B_DUTY(b),
      .CA(ca), .AN(an), .CONV_DONE(done));

   rgb_duty_seg_display #(.CH_W(CH_W), .REFRESH_DIV(DIV), .LZ_BLANK(1'b0)) u_dut_nz (
      .CLK(clk), .RST(rst_n), .R_DUTY(r), .G_DUTY(g), .B_DUTY(b),
      .CA(ca_nz), .AN(an_nz), .CONV_DONE(done_nz));

   int n_chk = 0, n_err = 0;

   typedef struct {
      int         slot;
      logic [7:0] ca;
   } exp_t;
   exp_t sb_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] seg(input int d);
      case (d)
         0: seg = 8'hC0; 1: seg = 8'hF9; 2: seg = 8'hA4; 3: seg = 8'hB0;
         4: seg = 8'h99; 5: seg = 8'h92; 6: seg = 8'h82; 7: seg = 8'hF8;
         8: seg = 8'h80; 9: seg = 8'h90; default: seg = 8'hFF;
      endcase
   endfunction

   function automatic logic [7:0] tens_exp(input int v, input bit lz);
      tens_exp = (lz && (v / 10) == 0) ? 8'hFF : seg(v / 10);
   endfunction

   // Expected cathodes for slots first..7 of one frame.
   task automatic push_frame(input int rv, input int gv, input int bv, input bit lz, input int first);
      logic [7:0] e [8];
      e[7] = tens_exp(rv, lz); e[6] = seg(rv % 10); e[5] = 8'hFF;
      e[4] = tens_exp(gv, lz); e[3] = seg(gv % 10); e[2] = 8'hFF;
      e[1] = tens_exp(bv, lz); e[0] = seg(bv % 10);
      for (int s = first; s < 8; s++) sb_q.push_back('{slot: s, ca: e[s]});
   endtask

   task automatic wait_slot(input bit nz, input int slot, output bit ok);
      logic [7:0] want;
      want = ~(8'h01 << slot);
      ok = 1'b0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if ((nz ? an_nz : an) == want) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk($sformatf("timeout_slot%0d", slot), nz ? an_nz : an, want);
   endtask

   // Drains the scoreboard against the scanned display.
   task automatic scan(input bit nz, input string pfx);
      exp_t e;
      bit   ok;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         wait_slot(nz, e.slot, ok);
         if (ok) chk($sformatf("%s_slot%0d", pfx, e.slot), nz ? ca_nz : ca, e.ca);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic release_check(input string pfx);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= DIV + 1; k++) begin
         @(posedge clk);
         #1;
         if (k == DIV) chk({pfx, "_an_dark"}, an, 8'hFF);
      end
      chk({pfx, "_an_first"}, an, 8'hFE);
      chk({pfx, "_ca_first"}, ca, 8'hC0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      int t, width, period;

      // reset state
      wait_cyc(3);
      chk("rst_an", an, 8'hFF);
      chk("rst_ca", ca, 8'hFF);
      chk("rst_done", done, 1'b0);
      chk("rst_an_nz", an_nz, 8'hFF);
      release_check("rel");

      // all zeros, both blanking modes
      wait_cyc(70);
      push_frame(0, 0, 0, 1'b1, 0);
      scan(1'b0, "zero");
      push_frame(0, 0, 0, 1'b0, 0);
      scan(1'b1, "zero_nz");

      // main pattern
      r = 5'd31; g = 5'd16; b = 5'd3;
      wait_cyc(70);
      push_frame(31, 16, 3, 1'b1, 0);
      scan(1'b0, "rgb");
      push_frame(31, 16, 3, 1'b0, 0);
      scan(1'b1, "rgb_nz");

      // mid-frame change must not disturb the frame in progress
      wait_slot(1'b0, 3, ok);
      r = 5'd7;
      push_frame(31, 16, 3, 1'b1, 3);
      scan(1'b0, "torn");
      wait_cyc(70);
      push_frame(7, 16, 3, 1'b1, 0);
      scan(1'b0, "newr");

      // CONV_DONE cadence
      for (int p = 0; p < 3; p++) begin
         t = 0;
         while (done !== 1'b1 && t < 60) begin @(negedge clk); t++; end
         chk("done_seen", done, 1'b1);
         width = 0;
         while (done === 1'b1 && width < 60) begin @(negedge clk); width++; end
         chk("done_width", width, 1);
         period = width;
         while (done !== 1'b1 && period < 60) begin @(negedge clk); period++; end
         chk("done_period", period, 3 * (CH_W + 2));
      end

      // asynchronous reset mid-scan
      wait_slot(1'b0, 4, ok);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_an", an, 8'hFF);
      chk("arst_ca", ca, 8'hFF);
      chk("arst_done", done, 1'b0);
      wait_cyc(2);
      release_check("rel2");
      wait_cyc(80);
      push_frame(7, 16, 3, 1'b1, 0);
      scan(1'b0, "recover");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
